// File: rtl/fwd_result_pipe_if.sv
// fwd_result_pipe_if: issue, result, lookup and writeback bundle for fwd_result_pipe.
interface fwd_result_pipe_if #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int LAT_W     = 3,
    parameter int NUM_RD    = 6
);
    logic [NUM_LANES-1:0]        iss_valid;
    logic [NUM_LANES*ADDR_W-1:0] iss_addr;
    logic [NUM_LANES-1:0]        iss_write;
    logic [NUM_LANES*LAT_W-1:0]  iss_lat;
    logic [NUM_LANES-1:0]        kill_mask;
    logic [NUM_LANES-1:0]        res_valid;
    logic [NUM_LANES*DATA_W-1:0] res_data;
    logic [NUM_RD*ADDR_W-1:0]    rd_addr;
    logic [NUM_RD-1:0]           rd_hit;
    logic [NUM_RD-1:0]           rd_stall;
    logic [NUM_RD*DATA_W-1:0]    rd_data;
    logic [NUM_LANES-1:0]        wb_valid;
    logic [NUM_LANES*ADDR_W-1:0] wb_addr;
    logic [NUM_LANES*DATA_W-1:0] wb_data;
    logic                        err_lat;
    logic                        err_orphan;
    modport master (
        output iss_valid, iss_addr, iss_write, iss_lat, kill_mask, res_valid, res_data, rd_addr,
        input  rd_hit, rd_stall, rd_data, wb_valid, wb_addr, wb_data, err_lat, err_orphan
    );
    modport slave (
        input  iss_valid, iss_addr, iss_write, iss_lat, kill_mask, res_valid, res_data, rd_addr,
        output rd_hit, rd_stall, rd_data, wb_valid, wb_addr, wb_data, err_lat, err_orphan
    );
endinterface

// File: rtl/fwd_result_pipe.sv
// fwd_result_pipe: per-lane DEPTH-stage result tracker with writeback and youngest-match forwarding.
// Optional macro RES_BYPASS_EN exposes a result to lookups in the cycle it is captured.
module fwd_result_pipe #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 7,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int LAT_W     = 3,
    parameter int NUM_RD    = 6
) (
    input logic              clk,
    input logic              reset,
    fwd_result_pipe_if.slave bus
);
    localparam int LAST = DEPTH - 1;
    logic [DEPTH-1:0][NUM_LANES-1:0]             vld, wr, rdy, due, cap, eff_rdy, lk_rdy;
    logic [DEPTH-1:0][NUM_LANES-1:0][ADDR_W-1:0] addr;
    logic [DEPTH-1:0][NUM_LANES-1:0][LAT_W-1:0]  cnt;
    logic [DEPTH-1:0][NUM_LANES-1:0][DATA_W-1:0] data, eff_data, lk_data;
    logic [NUM_LANES-1:0]        lat_bad, orphan, wb_miss, wb_valid;
    logic [NUM_LANES*ADDR_W-1:0] wb_addr;
    logic [NUM_LANES*DATA_W-1:0] wb_data;
    logic [NUM_RD-1:0]           rd_hit, rd_stall;
    logic [NUM_RD*DATA_W-1:0]    rd_data;
    logic                        err_lat, err_orphan;

    // eff_* is the entry as it will look after this cycle's result capture
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                due[s][l]      = vld[s][l] && cnt[s][l] == LAT_W'(1);
                cap[s][l]      = due[s][l] && bus.res_valid[l];
                eff_rdy[s][l]  = rdy[s][l] || cap[s][l];
                eff_data[s][l] = cap[s][l] ? bus.res_data[l*DATA_W +: DATA_W] : data[s][l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lat_bad[l] = bus.iss_valid[l] && !bus.kill_mask[l] &&
                         (bus.iss_lat[l*LAT_W +: LAT_W] == '0 || bus.iss_lat[l*LAT_W +: LAT_W] > LAT_W'(DEPTH));
            orphan[l]  = bus.res_valid[l];
            for (int s = 0; s < DEPTH; s++)
                if (due[s][l]) orphan[l] = 1'b0;
            wb_valid[l] = vld[LAST][l] && wr[LAST][l] && eff_rdy[LAST][l];
            wb_miss[l]  = vld[LAST][l] && wr[LAST][l] && !eff_rdy[LAST][l];
            wb_addr[l*ADDR_W +: ADDR_W] = wb_valid[l] ? addr[LAST][l] : '0;
            wb_data[l*DATA_W +: DATA_W] = wb_valid[l] ? eff_data[LAST][l] : '0;
        end
    end

`ifdef RES_BYPASS_EN
    assign lk_rdy  = eff_rdy;
    assign lk_data = eff_data;
`else
    assign lk_rdy  = rdy;
    assign lk_data = data;
`endif

    // walk oldest to youngest so the youngest match is the last one written
    always_comb begin
        rd_hit   = '0;
        rd_stall = '0;
        rd_data  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (vld[s][l] && wr[s][l] && addr[s][l] == bus.rd_addr[i*ADDR_W +: ADDR_W]) begin
                        rd_hit[i]                   = lk_rdy[s][l];
                        rd_stall[i]                 = !lk_rdy[s][l];
                        rd_data[i*DATA_W +: DATA_W] = lk_rdy[s][l] ? lk_data[s][l] : '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld        <= '0;
            rdy        <= '0;
            err_lat    <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                vld[0][l] <= bus.iss_valid[l] && !bus.kill_mask[l] && !lat_bad[l];
                rdy[0][l] <= 1'b0;
            end
            for (int s = 1; s < DEPTH; s++) begin
                vld[s] <= vld[s-1];
                rdy[s] <= eff_rdy[s-1];
            end
            err_lat    <= err_lat || (|lat_bad) || (|wb_miss);
            err_orphan <= err_orphan || (|orphan);
        end
    end

    // payload is qualified by vld, so it needs no reset
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            addr[0][l] <= bus.iss_addr[l*ADDR_W +: ADDR_W];
            wr[0][l]   <= bus.iss_write[l];
            cnt[0][l]  <= bus.iss_lat[l*LAT_W +: LAT_W];
            data[0][l] <= '0;
        end
        for (int s = 1; s < DEPTH; s++) begin
            addr[s] <= addr[s-1];
            wr[s]   <= wr[s-1];
            data[s] <= eff_data[s-1];
            for (int l = 0; l < NUM_LANES; l++)
                cnt[s][l] <= cnt[s-1][l] == '0 ? '0 : cnt[s-1][l] - LAT_W'(1);
        end
    end

    assign bus.wb_valid   = wb_valid;
    assign bus.wb_addr    = wb_addr;
    assign bus.wb_data    = wb_data;
    assign bus.rd_hit     = rd_hit;
    assign bus.rd_stall   = rd_stall;
    assign bus.rd_data    = rd_data;
    assign bus.err_lat    = err_lat;
    assign bus.err_orphan = err_orphan;
endmodule

// File: tb/tb_fwd_result_pipe.sv
// tb_fwd_result_pipe: directed vectors; writebacks checked by a scoreboard monitor, lookups and flags inline.
module tb_fwd_result_pipe;
    localparam int NL = 2, DEPTH = 7, DW = 128, AW = 7, LW = 3, NR = 6;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wb_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    int   t;
    wb_t  q0[$];
    wb_t  q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fwd_result_pipe_if #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW), .NUM_RD(NR)) bus ();

    fwd_result_pipe #(.NUM_LANES(NL), .DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW), .LAT_W(LW), .NUM_RD(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
        bus.iss_valid = '0;
        bus.kill_mask = '0;
        bus.res_valid = '0;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic issue(input int l, input int a, input int lat);
        bus.iss_valid[l]          = 1'b1;
        bus.iss_write[l]          = 1'b1;
        bus.iss_addr[l*AW +: AW]  = AW'(a);
        bus.iss_lat[l*LW +: LW]   = LW'(lat);
    endtask

    task automatic result(input int l, input logic [DW-1:0] d);
        bus.res_valid[l]         = 1'b1;
        bus.res_data[l*DW +: DW] = d;
    endtask

    task automatic look(input int p, input int a);
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic push_wb(input int l, input int a, input logic [DW-1:0] d, input int c);
        wb_t e;
        e.addr = AW'(a);
        e.data = d;
        e.cyc  = c;
        if (l == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_rd(input string nm, input int p, input logic h, input logic s, input logic [DW-1:0] d);
        vecs++;
        if (bus.rd_hit[p] !== h || bus.rd_stall[p] !== s || bus.rd_data[p*DW +: DW] !== d) begin
            errs++;
            $display("FAIL %s: hit/stall/data got %b/%b/%h, expected %b/%b/%h",
                     nm, bus.rd_hit[p], bus.rd_stall[p], bus.rd_data[p*DW +: DW], h, s, d);
        end
    endtask

    task automatic mon_lane(input int l);
        wb_t e;
        if (!bus.wb_valid[l]) return;
        vecs++;
        if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0)) begin
            errs++;
            $display("FAIL wb_unexpected lane%0d cyc %0d: got addr=%0d data=%h, expected no writeback",
                     l, cyc, bus.wb_addr[l*AW +: AW], bus.wb_data[l*DW +: DW]);
            return;
        end
        if (l == 0) e = q0.pop_front();
        else e = q1.pop_front();
        if (bus.wb_addr[l*AW +: AW] !== e.addr || bus.wb_data[l*DW +: DW] !== e.data || cyc != e.cyc) begin
            errs++;
            $display("FAIL wb_lane%0d: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                     l, bus.wb_addr[l*AW +: AW], bus.wb_data[l*DW +: DW], cyc, e.addr, e.data, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon_lane(0);
            mon_lane(1);
        end
    end

    initial begin
        reset         = 1'b1;
        bus.iss_valid = '0;
        bus.iss_addr  = '0;
        bus.iss_write = '0;
        bus.iss_lat   = '0;
        bus.kill_mask = '0;
        bus.res_valid = '0;
        bus.res_data  = '0;
        bus.rd_addr   = '0;
        next_cycle;
        next_cycle;
        reset = 1'b0;
        settle;
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_rd_hit", 32'(bus.rd_hit), 32'd0);
        chk("rst_rd_stall", 32'(bus.rd_stall), 32'd0);
        chk("rst_err", 32'({bus.err_lat, bus.err_orphan}), 32'd0);

        // lane0 addr 5 lat 2, result 0xA5 two cycles after issue
        next_cycle; t = cyc;
        issue(0, 5, 2); look(0, 5); push_wb(0, 5, 128'hA5, t + 7);
        settle; chk_rd("t1_empty", 0, 0, 0, '0);
        next_cycle; settle; chk_rd("t1_pending", 0, 0, 1, '0);
        next_cycle; result(0, 128'hA5); settle;
`ifdef RES_BYPASS_EN
        chk_rd("t1_capture", 0, 1, 0, 128'hA5);
`else
        chk_rd("t1_capture", 0, 0, 1, '0);
`endif
        next_cycle; settle; chk_rd("t1_ready", 0, 1, 0, 128'hA5);
        repeat (5) begin next_cycle; settle; end
        chk_rd("t1_retired", 0, 0, 0, '0);

        // older ready 0x11 must not override younger pending lane1 entry
        next_cycle; t = cyc;
        issue(0, 9, 1); look(0, 9); push_wb(0, 9, 128'h11, t + 7);
        settle;
        next_cycle; result(0, 128'h11); issue(1, 9, 4); push_wb(1, 9, 128'h22, t + 8);
        settle;
`ifdef RES_BYPASS_EN
        chk_rd("t2_t1", 0, 1, 0, 128'h11);
`else
        chk_rd("t2_t1", 0, 0, 1, '0);
`endif
        for (int k = 2; k <= 4; k++) begin
            next_cycle; settle; chk_rd($sformatf("t2_stall_%0d", k), 0, 0, 1, '0);
        end
        next_cycle; result(1, 128'h22); settle;
`ifdef RES_BYPASS_EN
        chk_rd("t2_capture", 0, 1, 0, 128'h22);
`else
        chk_rd("t2_capture", 0, 0, 1, '0);
`endif
        next_cycle; settle; chk_rd("t2_ready", 0, 1, 0, 128'h22);
        repeat (4) begin next_cycle; settle; end

        // same-cycle issue to addr 3: lane1 is younger
        next_cycle; t = cyc;
        issue(0, 3, 1); issue(1, 3, 1); look(0, 3);
        push_wb(0, 3, 128'h1, t + 7); push_wb(1, 3, 128'h2, t + 7);
        settle;
        next_cycle; result(0, 128'h1); result(1, 128'h2); settle;
        next_cycle; settle; chk_rd("t3_younger_lane", 0, 1, 0, 128'h2);
        repeat (6) begin next_cycle; settle; end

        // kill lane0, lane1 proceeds
        next_cycle; t = cyc;
        issue(0, 12, 1); issue(1, 12, 1); bus.kill_mask = 2'b01; look(0, 12); look(5, 77);
        push_wb(1, 12, 128'h44, t + 7);
        settle;
        next_cycle; result(1, 128'h44); settle;
        next_cycle; settle;
        chk_rd("t4_kill_hit", 0, 1, 0, 128'h44);
        chk_rd("t4_nomatch", 5, 0, 0, '0);
        chk("t4_err_clean", 32'({bus.err_lat, bus.err_orphan}), 32'd0);
        repeat (6) begin next_cycle; settle; end

        // illegal latency, orphan result, then reset with an entry in flight
        next_cycle;
        issue(0, 20, 0); settle;
        chk("t5_err_lat_pre", 32'(bus.err_lat), 32'd0);
        next_cycle; result(1, 128'h99); look(0, 20); settle;
        chk("t5_err_lat", 32'(bus.err_lat), 32'd1);
        chk("t5_err_orphan_pre", 32'(bus.err_orphan), 32'd0);
        chk_rd("t5_bubble", 0, 0, 0, '0);
        next_cycle; issue(0, 30, 1); settle;
        chk("t5_err_orphan", 32'(bus.err_orphan), 32'd1);
        next_cycle; result(0, 128'h33); look(0, 30); settle;
        next_cycle; settle;
        chk_rd("t5_inflight", 0, 1, 0, 128'h33);
        chk("t5_sticky", 32'({bus.err_lat, bus.err_orphan}), 32'd3);
        next_cycle; reset = 1'b1; settle;
        next_cycle; reset = 1'b0; settle;
        chk("t5_rst_err", 32'({bus.err_lat, bus.err_orphan}), 32'd0);
        chk("t5_rst_wb", 32'(bus.wb_valid), 32'd0);
        chk_rd("t5_rst_rd", 0, 0, 0, '0);
        repeat (10) begin next_cycle; settle; end

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
